// File: rtl/br_local_injector_pkg.sv
`default_nettype none
// ======================================================================
// br_local_injector_pkg -- BrLite frame type, injector constants | rev 1.0
// ======================================================================
package br_local_injector_pkg;

  localparam int unsigned BR_ADDR_W     = 16;
  localparam int unsigned BR_PAYLOAD_W  = 32;
  localparam int unsigned BR_KSVC_W     = 5;
  localparam int unsigned BR_INJ_WAIT_W = 32;

  typedef struct packed {
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ADDR_W-1:0]    seq_source;
    logic [BR_ADDR_W-1:0]    target;
    logic [BR_KSVC_W-1:0]    ksvc;
    logic                    clear;
  } br_data_t;

  typedef enum logic [1:0] {
    BR_INJ_IDLE = 2'd0,
    BR_INJ_SEND = 2'd1,
    BR_INJ_GAP  = 2'd2
  } br_inj_state_t;

  function automatic logic [BR_INJ_WAIT_W-1:0] br_sat_inc(input logic [BR_INJ_WAIT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_local_injector_if.sv
`default_nettype none
// ======================================================================
// br_local_injector_if -- PE push side and router rx/ack side | rev 1.0
// ======================================================================
interface br_local_injector_if;
  import br_local_injector_pkg::*;

  logic     req_i;
  br_data_t req_data_i;
  logic     ready_o;
  logic     rx_o;
  br_data_t data_o;
  logic     ack_i;

  // master: the injector itself; slave: the PE/router environment around it
  modport master (input req_i, req_data_i, ack_i, output ready_o, rx_o, data_o);
  modport slave  (output req_i, req_data_i, ack_i, input ready_o, rx_o, data_o);

endinterface
`default_nettype wire

// File: rtl/br_inject_fifo.sv
`default_nettype none
// ======================================================================
// br_inject_fifo -- sync FIFO with registered count, full, empty | rev 1.0
// ======================================================================
module br_inject_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  T                 mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/br_local_injector.sv
`default_nettype none
// ======================================================================
// br_local_injector -- buffered BrLite frame feeder with wait stats | rev 1.0
// ======================================================================
module br_local_injector
  import br_local_injector_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] ADDRESS        = 16'h0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  br_local_injector_if.master      bus,
  output logic [BR_INJ_WAIT_W-1:0] last_wait_o,
  output logic [31:0]              sent_cnt_o,
  output logic                     timeout_o,
  output logic [15:0]              src_addr_o
);

  br_data_t                  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      fifo_full, fifo_empty, fifo_pop;

  br_inj_state_t             state_q, state_d;
  logic                      rx_q, rx_d;
  br_data_t                  data_q, data_d;
  logic [BR_INJ_WAIT_W-1:0]  wait_q, wait_d;
  logic [BR_INJ_WAIT_W-1:0]  last_q, last_d;
  logic [31:0]               sent_q, sent_d;
  logic                      tmo_q, tmo_d;

  br_inject_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (br_data_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.req_i),
    .data_i  (bus.req_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // No bypass: a pop in this cycle only frees a slot on the next one
  assign bus.ready_o = !fifo_full;
  assign bus.rx_o    = rx_q;
  assign bus.data_o  = data_q;
  assign last_wait_o = last_q;
  assign sent_cnt_o  = sent_q;
  assign timeout_o   = tmo_q;
  assign src_addr_o  = ADDRESS;

  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    data_d   = data_q;
    wait_d   = wait_q;
    last_d   = last_q;
    sent_d   = sent_q;
    tmo_d    = tmo_q;
    fifo_pop = 1'b0;
    case (state_q)
      BR_INJ_IDLE: begin
        if (fifo_count != '0) begin
          data_d  = fifo_head;
          rx_d    = 1'b1;
          wait_d  = '0;
          state_d = BR_INJ_SEND;
        end
      end
      BR_INJ_SEND: begin
        if (bus.ack_i) begin
          fifo_pop = !fifo_empty;
          last_d   = wait_q;
          if (!data_q.clear) sent_d = sent_q + 32'd1;
          rx_d     = 1'b0;
          state_d  = BR_INJ_GAP;
        end else begin
          wait_d = br_sat_inc(wait_q);
          if (wait_d >= BR_INJ_WAIT_W'(TIMEOUT_CYCLES - 1)) tmo_d = 1'b1;
        end
      end
      BR_INJ_GAP: state_d = BR_INJ_IDLE;
      default:    state_d = BR_INJ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BR_INJ_IDLE;
      rx_q    <= 1'b0;
      data_q  <= '0;
      wait_q  <= '0;
      last_q  <= '0;
      sent_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      sent_q  <= sent_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_br_local_injector.sv
`default_nettype none
// ======================================================================
// tb_br_local_injector -- random + directed bench with queue model | rev 1.0
// ======================================================================
module tb_br_local_injector;
  import br_local_injector_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;
  localparam logic [15:0] ADDR  = 16'hA5C3;

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] last_wait_o, sent_cnt_o;
  logic        timeout_o;
  logic [15:0] src_addr_o;

  always #5 clk_i = ~clk_i;

  br_local_injector_if bus ();

  br_local_injector #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .ADDRESS        (ADDR)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .last_wait_o (last_wait_o),
    .sent_cnt_o  (sent_cnt_o),
    .timeout_o   (timeout_o),
    .src_addr_o  (src_addr_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: frames in flight are a queue; the head is on the wire while m_rx
  br_data_t    mq[$];
  bit          m_rx, m_gap, m_tmo, m_pushed;
  logic [31:0] m_wait, m_last, m_sent;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic br_data_t rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return br_data_t'(r[$bits(br_data_t)-1:0]);
  endfunction

  function automatic br_data_t mk(input int ksvc, input bit clr);
    br_data_t d;
    d       = rand_data();
    d.ksvc  = ksvc[4:0];
    d.clear = clr;
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rx = 0; m_gap = 0; m_tmo = 0; m_pushed = 0;
    m_wait = 0; m_last = 0; m_sent = 0;
  endtask

  task automatic model_edge();
    int       sz;
    br_data_t pd;
    sz       = mq.size();
    pd       = bus.req_data_i;
    m_pushed = bus.req_i && (sz < DEPTH);
    if (m_rx) begin
      if (bus.ack_i) begin
        m_last = m_wait;
        if (!mq[0].clear) m_sent = m_sent + 1;
        void'(mq.pop_front());
        m_rx  = 0;
        m_gap = 1;
      end else begin
        if (m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 1;
        if (m_wait >= TMO - 1) m_tmo = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (sz > 0) begin
      m_rx   = 1;
      m_wait = 0;
    end
    if (m_pushed) mq.push_back(pd);
  endtask

  task automatic check_all();
    chk("ready", 128'(bus.ready_o), 128'(mq.size() < DEPTH));
    chk("rx", 128'(bus.rx_o), 128'(m_rx));
    if (m_rx) chk("data", 128'(bus.data_o), 128'(mq[0]));
    chk("last_wait", 128'(last_wait_o), 128'(m_last));
    chk("sent_cnt", 128'(sent_cnt_o), 128'(m_sent));
    chk("timeout", 128'(timeout_o), 128'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push_frame(input br_data_t d);
    bus.req_i      = 1'b1;
    bus.req_data_i = d;
    m_pushed       = 0;
    for (int i = 0; i < 40 && !m_pushed; i++) step();
    bus.req_i = 1'b0;
    chk("push_bound", 128'(m_pushed), 128'(1));
  endtask

  task automatic wait_rx();
    for (int i = 0; i < 20 && !bus.rx_o; i++) step();
    chk("rx_rise", 128'(bus.rx_o), 128'(1));
  endtask

  task automatic drain();
    bus.req_i = 1'b0;
    bus.ack_i = 1'b1;
    for (int i = 0; i < 60 && (mq.size() != 0 || m_rx || m_gap); i++) step();
    bus.ack_i = 1'b0;
    chk("drain_empty", 128'(mq.size()), 128'(0));
  endtask

  logic [31:0] sent_before;

  initial begin
    bus.req_i      = 1'b0;
    bus.req_data_i = '0;
    bus.ack_i      = 1'b0;
    model_reset();

    #12;
    chk("rst_rx", 128'(bus.rx_o), 128'(0));
    chk("rst_data", 128'(bus.data_o), 128'(0));
    chk("rst_ready", 128'(bus.ready_o), 128'(1));
    chk("rst_sent", 128'(sent_cnt_o), 128'(0));
    chk("rst_last", 128'(last_wait_o), 128'(0));
    chk("rst_tmo", 128'(timeout_o), 128'(0));
    chk("src_addr", 128'(src_addr_o), 128'(ADDR));
    #8 rst_ni = 1'b1;

    // Single frame: rx one edge after the push, 5 wait edges, then ack
    push_frame(mk(3, 1'b0));
    chk("rx_not_yet", 128'(bus.rx_o), 128'(0));
    step();
    chk("rx_up", 128'(bus.rx_o), 128'(1));
    for (int i = 0; i < 5; i++) step();
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    chk("lw_5", 128'(last_wait_o), 128'(5));
    chk("sent_1", 128'(sent_cnt_o), 128'(1));
    step();
    chk("gap_low1", 128'(bus.rx_o), 128'(0));
    // Stray acks in IDLE with an empty FIFO
    bus.ack_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.ack_i = 1'b0;
    chk("stray_sent", 128'(sent_cnt_o), 128'(1));

    // Fill: four accepted, fifth held off by ready_o
    for (int i = 0; i < 4; i++) push_frame(mk(i + 4, 1'b0));
    chk("full_ready", 128'(bus.ready_o), 128'(0));
    bus.req_i      = 1'b1;
    bus.req_data_i = mk(9, 1'b0);
    m_pushed       = 0;
    for (int i = 0; i < 3; i++) step();
    bus.ack_i = 1'b1;
    for (int i = 0; i < 60 && (bus.req_i || mq.size() != 0 || m_rx); i++) begin
      step();
      if (m_pushed) bus.req_i = 1'b0;
    end
    bus.ack_i = 1'b0;
    chk("fill_sent", 128'(sent_cnt_o), 128'(6));
    chk("fill_lw0", 128'(last_wait_o), 128'(0));

    // Clear frame: counted in last_wait but not in sent_cnt
    push_frame(mk(1, 1'b1));
    wait_rx();
    for (int i = 0; i < 2; i++) step();
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    chk("clr_sent", 128'(sent_cnt_o), 128'(6));
    chk("clr_lw", 128'(last_wait_o), 128'(2));
    step();

    // Timeout at the 7th wait edge with TIMEOUT_CYCLES=8
    for (int i = 0; i < 3; i++) step();
    chk("tmo_clear", 128'(timeout_o), 128'(0));
    push_frame(mk(2, 1'b0));
    wait_rx();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 6) chk("tmo_pre", 128'(timeout_o), 128'(0));
      if (i == 7) chk("tmo_set", 128'(timeout_o), 128'(1));
    end
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    chk("tmo_lw20", 128'(last_wait_o), 128'(20));
    chk("tmo_sticky", 128'(timeout_o), 128'(1));

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bus.req_i      = ($urandom_range(0, 99) < 60);
      bus.req_data_i = rand_data();
      bus.ack_i      = ($urandom_range(0, 99) < 35);
      step();
    end
    drain();

    // Reset mid-frame with three frames queued behind the one on the wire
    for (int i = 0; i < 4; i++) push_frame(mk(i, 1'b0));
    wait_rx();
    chk("pre_rst_q", 128'(mq.size()), 128'(4));
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_rx", 128'(bus.rx_o), 128'(0));
    chk("arst_sent", 128'(sent_cnt_o), 128'(0));
    chk("arst_last", 128'(last_wait_o), 128'(0));
    chk("arst_tmo", 128'(timeout_o), 128'(0));
    chk("arst_ready", 128'(bus.ready_o), 128'(1));
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    sent_before = sent_cnt_o;
    push_frame(mk(7, 1'b0));
    step();
    chk("post_rst_rx", 128'(bus.rx_o), 128'(1));
    bus.ack_i = 1'b1;
    step();
    bus.ack_i = 1'b0;
    chk("post_rst_sent", 128'(sent_cnt_o), 128'(sent_before + 1));
    for (int i = 0; i < 3; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
